obi_mem_port_arbiter: RTL and testbench
=======================================

Name: obi_mem_port_arbiter

Overview:
- Shares one single-ported OBI memory slave port (mm_ram-style req/gnt/rvalid) between the core instruction fetch master (M0, read-only) and the core data master (M1).
- Arbitrates each request cycle and holds the granted master's request stable until the slave grants it.
- Records the owner of every outstanding transaction in an in-order route FIFO, and steers each response back to that owner.
- Sits between cv32e40p_core and a single-port memory in the core testbench.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, rdata/wdata width; be width is DATA_WIDTH/8.
- MAX_OUTSTANDING, 2, route FIFO depth and maximum number of unanswered granted transactions; must be a power of 2 and >= 1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- m0_req_i  in  1  instr request
- m0_gnt_o  out  1  instr grant
- m0_addr_i  in  ADDR_WIDTH  instr address
- m0_rvalid_o  out  1  instr response valid
- m0_rdata_o  out  DATA_WIDTH  instr read data
- m1_req_i  in  1  data request
- m1_gnt_o  out  1  data grant
- m1_addr_i  in  ADDR_WIDTH  data address
- m1_we_i  in  1  data write enable
- m1_be_i  in  DATA_WIDTH/8  byte enables
- m1_wdata_i  in  DATA_WIDTH  write data
- m1_rvalid_o  out  1  data response valid
- m1_rdata_o  out  DATA_WIDTH  data read data
- s_req_o  out  1  slave request
- s_gnt_i  in  1  slave grant
- s_addr_o  out  ADDR_WIDTH  slave address
- s_we_o  out  1  slave write enable
- s_be_o  out  DATA_WIDTH/8  slave byte enables
- s_wdata_o  out  DATA_WIDTH  slave write data
- s_rvalid_i  in  1  slave response valid
- s_rdata_i  in  DATA_WIDTH  slave read data
- err_o  out  1  sticky protocol error

Behaviour:
- Reset (rst_i high at a clk_i edge):
  - Route FIFO emptied; outstanding count = 0; state = ARB_IDLE.
  - RR pointer set so M1 wins the first conflict; err_o = 0.
  - While rst_i is high: s_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o all 0.
- Grant path is combinational, zero added latency:
  - s_req_o = (m0_req_i | m1_req_i) & !full & !rst_i.
  - The selected master's addr/we/be/wdata are muxed onto s_*. For M0, s_we_o = 0, s_be_o = all ones, s_wdata_o = 0.
  - m<sel>_gnt_o = s_req_o & s_gnt_i; the non-selected master's gnt = 0.
- Selection in ARB_IDLE:
  - Only one master requesting: that master is selected.
  - Both requesting: fixed priority, M1 over M0 (see Optional Feature).
- State machine:
  - ARB_IDLE -> ARB_WAIT_GNT when s_req_o & !s_gnt_i; the selected ID is latched as lock_id.
  - In ARB_WAIT_GNT, selection = lock_id regardless of other requests (OBI address stability).
  - ARB_WAIT_GNT -> ARB_IDLE on s_gnt_i.
  - If the locked master drops req (illegal per OBI): set err_o, return to ARB_IDLE.
- Full (count == MAX_OUTSTANDING): s_req_o forced 0, even if s_rvalid_i pops in the same cycle. No pass-through.
- Push: the granted ID is pushed into the route FIFO on s_req_o & s_gnt_i.
- Pop:
  - On s_rvalid_i the head ID is popped.
  - m<head>_rvalid_o = s_rvalid_i; the other master's rvalid = 0.
  - s_rdata_i is broadcast to both rdata outputs.
  - Response may arrive the cycle after grant at the earliest.
- Simultaneous push and pop with count < MAX: count unchanged; FIFO order preserved.
- s_rvalid_i with an empty FIFO: err_o set (sticky until reset); both rvalids = 0.
- Reset mid-transaction: all outstanding owners are dropped. A stale s_rvalid_i after reset raises err_o.
- Count width is $clog2(MAX_OUTSTANDING+1); FIFO pointers wrap modulo MAX_OUTSTANDING.

Optional Feature:
- Macro OBI_ARB_ROUND_ROBIN_EN.
- Defined: on a conflict in ARB_IDLE, the master not granted last wins. The RR pointer updates on each granted request only.
- Undefined: fixed priority, M1 always beats M0; RR pointer logic is absent.

Decomposition:
- Package obi_arb_pkg:
  - typedef enum logic {MST_INSTR=0, MST_DATA=1} master_id_e.
  - typedef enum logic {ARB_IDLE, ARB_WAIT_GNT} arb_state_e.
- Sub-module obi_arb_route_fifo:
  - Parameterised depth; stores master_id_e.
  - push/pop/full/empty/count outputs.
  - Synchronous active-high reset.

Test Plan:
- M1 req only, s_gnt_i=1, rdata 0xDEADBEEF returned next cycle -> m1_gnt_o=1 same cycle, m1_rvalid_o=1 with 0xDEADBEEF, m0_rvalid_o=0.
- Both req in the same cycle, s_gnt_i=1 -> M1 granted first. M0 granted the following cycle if M1 drops req. With OBI_ARB_ROUND_ROBIN_EN and both held: grants alternate M1,M0,M1,M0.
- M0 req, s_gnt_i=0 for 3 cycles while M1 raises req in cycle 1 -> s_addr_o stays at M0 addr 0x80 until gnt; M1 granted only afterwards.
- Grants M0, M1, M0 with slave stalling rvalid and MAX_OUTSTANDING=2 -> third request blocked (s_req_o=0) until the first rvalid. Responses are routed M0, M1, M0 in order.
- s_rvalid_i pulse with no outstanding -> err_o=1 next cycle and stays 1. rst_i=1 for one cycle -> err_o=0, count=0.

Source files
------------

// File: rtl/obi_arb_pkg.sv
// ============================================================================
//  Module   : obi_arb_pkg
//  Purpose  : Shared types for the two-master OBI memory port arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package obi_arb_pkg;

  typedef enum logic {
    MST_INSTR = 1'b0,
    MST_DATA  = 1'b1
  } master_id_e;

  typedef enum logic {
    ARB_IDLE     = 1'b0,
    ARB_WAIT_GNT = 1'b1
  } arb_state_e;

  function automatic master_id_e other_master(input master_id_e id);
    return (id == MST_INSTR) ? MST_DATA : MST_INSTR;
  endfunction

endpackage

`default_nettype wire

// File: rtl/obi_arb_route_fifo.sv
// ============================================================================
//  Module   : obi_arb_route_fifo
//  Purpose  : In-order FIFO of master IDs owning outstanding transactions.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module obi_arb_route_fifo
  import obi_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  master_id_e       push_id_i,
  input  logic             pop_i,
  output master_id_e       head_id_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  master_id_e       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o    = (r_count == CNT_W'(DEPTH));
  assign empty_o   = (r_count == '0);
  assign count_o   = r_count;
  assign head_id_o = r_mem[r_rd_ptr];
  assign w_push    = push_i && !full_o;
  assign w_pop     = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_id_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/obi_mem_port_arbiter.sv
// ============================================================================
//  Module   : obi_mem_port_arbiter
//  Purpose  : Shares one OBI slave port between instr (M0) and data (M1)
//             masters; responses are routed back in order via a route FIFO.
//  Options  : OBI_ARB_ROUND_ROBIN_EN - round-robin on conflicts instead of
//             fixed M1-over-M0 priority.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module obi_mem_port_arbiter
  import obi_arb_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    m0_req_i,
  output logic                    m0_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  output logic                    m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  input  logic                    m1_req_i,
  output logic                    m1_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic                    m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic                    s_req_o,
  input  logic                    s_gnt_i,
  output logic [ADDR_WIDTH-1:0]   s_addr_o,
  output logic                    s_we_o,
  output logic [DATA_WIDTH/8-1:0] s_be_o,
  output logic [DATA_WIDTH-1:0]   s_wdata_o,
  input  logic                    s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   s_rdata_i,
  output logic                    err_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  arb_state_e       r_state;
  master_id_e       r_lock_id;
  logic             r_err;
  master_id_e       w_sel;
  master_id_e       w_head;
  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_fifo_full;
  logic             w_empty;
  logic             w_req;
  logic             w_grant;
  logic             w_resp;
  logic             w_lock_drop;
  logic             w_stray;

`ifdef OBI_ARB_ROUND_ROBIN_EN
  master_id_e r_last_gnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last_gnt <= MST_INSTR;
    end else if (w_grant) begin
      r_last_gnt <= w_sel;
    end
  end
`endif

  always_comb begin
    w_sel = MST_DATA;
    if (r_state == ARB_WAIT_GNT) begin
      w_sel = r_lock_id;
    end else if (m0_req_i && !m1_req_i) begin
      w_sel = MST_INSTR;
    end else if (m0_req_i && m1_req_i) begin
`ifdef OBI_ARB_ROUND_ROBIN_EN
      w_sel = other_master(r_last_gnt);
`else
      w_sel = MST_DATA;
`endif
    end
  end

  // Full blocks new requests even when a response pops this cycle.
  assign w_full   = (w_count == CNT_W'(MAX_OUTSTANDING));
  assign w_req    = (m0_req_i || m1_req_i) && !w_full && !rst_i;
  assign w_grant  = w_req && s_gnt_i;
  assign w_resp   = s_rvalid_i && !w_empty && !rst_i;
  assign w_stray  = s_rvalid_i && w_empty;
  assign w_lock_drop = (r_state == ARB_WAIT_GNT) &&
                       !((r_lock_id == MST_INSTR) ? m0_req_i : m1_req_i);

  assign s_req_o   = w_req;
  assign s_addr_o  = (w_sel == MST_INSTR) ? m0_addr_i : m1_addr_i;
  assign s_we_o    = (w_sel == MST_DATA) && m1_we_i;
  assign s_be_o    = (w_sel == MST_INSTR) ? {(DATA_WIDTH/8){1'b1}} : m1_be_i;
  assign s_wdata_o = (w_sel == MST_INSTR) ? '0 : m1_wdata_i;

  assign m0_gnt_o    = w_grant && (w_sel == MST_INSTR);
  assign m1_gnt_o    = w_grant && (w_sel == MST_DATA);
  assign m0_rvalid_o = w_resp && (w_head == MST_INSTR);
  assign m1_rvalid_o = w_resp && (w_head == MST_DATA);
  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;
  assign err_o       = r_err;

  obi_arb_route_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_route_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (w_grant && !w_fifo_full),
    .push_id_i (w_sel),
    .pop_i     (s_rvalid_i),
    .head_id_o (w_head),
    .full_o    (w_fifo_full),
    .empty_o   (w_empty),
    .count_o   (w_count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ARB_IDLE;
      r_lock_id <= MST_INSTR;
      r_err     <= 1'b0;
    end else begin
      if (w_stray || w_lock_drop) r_err <= 1'b1;
      case (r_state)
        ARB_IDLE: begin
          if (w_req && !s_gnt_i) begin
            r_state   <= ARB_WAIT_GNT;
            r_lock_id <= w_sel;
          end
        end
        ARB_WAIT_GNT: begin
          if (w_lock_drop || w_grant) r_state <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_obi_mem_port_arbiter.sv
// ============================================================================
//  Module   : tb_obi_mem_port_arbiter
//  Purpose  : Self-checking bench: directed vector table, corner sequences and
//             randomized traffic against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_obi_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 2;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            m0_req_i = 1'b0, m1_req_i = 1'b0, m1_we_i = 1'b0;
  logic            s_gnt_i = 1'b0, s_rvalid_i = 1'b0;
  logic [AW-1:0]   m0_addr_i = '0, m1_addr_i = '0;
  logic [DW/8-1:0] m1_be_i = '0;
  logic [DW-1:0]   m1_wdata_i = '0, s_rdata_i = '0;
  logic            m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
  logic [DW-1:0]   m0_rdata_o, m1_rdata_o, s_wdata_o;
  logic            s_req_o, s_we_o, err_o;
  logic [AW-1:0]   s_addr_o;
  logic [DW/8-1:0] s_be_o;

  always #5 clk_i = ~clk_i;

  obi_mem_port_arbiter #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_i (clk_i), .rst_i (rst_i),
    .m0_req_i (m0_req_i), .m0_gnt_o (m0_gnt_o), .m0_addr_i (m0_addr_i),
    .m0_rvalid_o (m0_rvalid_o), .m0_rdata_o (m0_rdata_o),
    .m1_req_i (m1_req_i), .m1_gnt_o (m1_gnt_o), .m1_addr_i (m1_addr_i),
    .m1_we_i (m1_we_i), .m1_be_i (m1_be_i), .m1_wdata_i (m1_wdata_i),
    .m1_rvalid_o (m1_rvalid_o), .m1_rdata_o (m1_rdata_o),
    .s_req_o (s_req_o), .s_gnt_i (s_gnt_i), .s_addr_o (s_addr_o),
    .s_we_o (s_we_o), .s_be_o (s_be_o), .s_wdata_o (s_wdata_o),
    .s_rvalid_i (s_rvalid_i), .s_rdata_i (s_rdata_i), .err_o (err_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: owners of outstanding transactions, pending (ungranted) owner
  int mq[$];
  bit lock_v;
  int lock_w;
  bit m_err;
`ifdef OBI_ARB_ROUND_ROBIN_EN
  int rr_last;
`endif

  task automatic model_reset();
    mq.delete();
    lock_v = 0;
    lock_w = 0;
    m_err  = 0;
`ifdef OBI_ARB_ROUND_ROBIN_EN
    rr_last = 0;
`endif
  endtask

  function automatic int conflict_winner();
`ifdef OBI_ARB_ROUND_ROBIN_EN
    return (rr_last == 1) ? 0 : 1;
`else
    return 1;
`endif
  endfunction

  task automatic idle_inputs();
    m0_req_i = 0; m1_req_i = 0; m1_we_i = 0; m1_be_i = '0; m1_wdata_i = '0;
    s_gnt_i = 0; s_rvalid_i = 0; s_rdata_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1; m0_req_i = 1; m1_req_i = 1; s_gnt_i = 1; s_rvalid_i = 1;
    #1;
    chk("rst_s_req", s_req_o, 0);
    chk("rst_gnt0", m0_gnt_o, 0);
    chk("rst_gnt1", m1_gnt_o, 0);
    chk("rst_rv0", m0_rvalid_o, 0);
    chk("rst_rv1", m1_rvalid_o, 0);
    @(negedge clk_i);
    rst_i = 0;
    idle_inputs();
    #1;
    chk("rst_err", err_o, 0);
    model_reset();
  endtask

  typedef struct {
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr;
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_g0, e_g1, e_r0, e_r1, e_err;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r0, input logic r1, input logic [31:0] a0,
                     input logic [31:0] a1, input logic g, input logic rv,
                     input logic [31:0] rd, input logic er, input logic [31:0] ea,
                     input logic eg0, input logic eg1, input logic er0,
                     input logic er1, input logic ee);
    vec_t v;
    v.m0_req = r0; v.m1_req = r1; v.m0_addr = a0; v.m1_addr = a1;
    v.gnt = g; v.rv = rv; v.rdata = rd; v.e_req = er; v.e_addr = ea;
    v.e_g0 = eg0; v.e_g1 = eg1; v.e_r0 = er0; v.e_r1 = er1; v.e_err = ee;
    tv.push_back(v);
  endtask

  task automatic apply_row(input int i, input vec_t v);
    string tag;
    @(negedge clk_i);
    tag = $sformatf("row%0d", i);
    m0_req_i = v.m0_req; m1_req_i = v.m1_req; m0_addr_i = v.m0_addr;
    m1_addr_i = v.m1_addr; m1_we_i = 0; m1_be_i = 4'hF; m1_wdata_i = '0;
    s_gnt_i = v.gnt; s_rvalid_i = v.rv; s_rdata_i = v.rdata;
    #1;
    chk({tag, "_s_req"}, s_req_o, v.e_req);
    if (v.e_req) chk({tag, "_s_addr"}, s_addr_o, v.e_addr);
    chk({tag, "_gnt0"}, m0_gnt_o, v.e_g0);
    chk({tag, "_gnt1"}, m1_gnt_o, v.e_g1);
    chk({tag, "_rv0"}, m0_rvalid_o, v.e_r0);
    chk({tag, "_rv1"}, m1_rvalid_o, v.e_r1);
    chk({tag, "_rdata0"}, m0_rdata_o, v.rdata);
    chk({tag, "_rdata1"}, m1_rdata_o, v.rdata);
    chk({tag, "_err"}, err_o, v.e_err);
  endtask

  initial begin
    bit g0_prev, g1_prev;
    int prev, sel;
    bit full, e_req, e_gnt, exp1;

    //  m0 m1 a0     a1     g  rv rdata         req addr   g0 g1 r0 r1 err
    add(0, 0, 0,     0,     0, 0, 0,            0, 0,      0, 0, 0, 0, 0);
    add(0, 1, 0,     32'h100, 1, 0, 0,          1, 32'h100, 0, 1, 0, 0, 0);
    add(0, 0, 0,     0,     0, 1, 32'hDEADBEEF, 0, 0,      0, 0, 0, 1, 0);
    add(1, 1, 32'h80, 32'h200, 1, 0, 0,         1, 32'h200, 0, 1, 0, 0, 0);
    add(1, 0, 32'h80, 0,    1, 1, 32'h11,       1, 32'h80, 1, 0, 0, 1, 0);
    add(0, 0, 0,     0,     0, 1, 32'h22,       0, 0,      0, 0, 1, 0, 0);
    add(1, 0, 32'h80, 0,    0, 0, 0,            1, 32'h80, 0, 0, 0, 0, 0);
    add(1, 1, 32'h80, 32'h300, 0, 0, 0,         1, 32'h80, 0, 0, 0, 0, 0);
    add(1, 1, 32'h80, 32'h300, 0, 0, 0,         1, 32'h80, 0, 0, 0, 0, 0);
    add(1, 1, 32'h80, 32'h300, 1, 0, 0,         1, 32'h80, 1, 0, 0, 0, 0);
    add(0, 1, 0,     32'h300, 1, 0, 0,          1, 32'h300, 0, 1, 0, 0, 0);
    add(1, 0, 32'h84, 0,    1, 0, 0,            0, 0,      0, 0, 0, 0, 0);
    add(1, 0, 32'h84, 0,    1, 1, 32'hA0,       0, 0,      0, 0, 1, 0, 0);
    add(1, 0, 32'h84, 0,    1, 0, 0,            1, 32'h84, 1, 0, 0, 0, 0);
    add(0, 0, 0,     0,     0, 1, 32'hA1,       0, 0,      0, 0, 0, 1, 0);
    add(0, 0, 0,     0,     0, 1, 32'hA2,       0, 0,      0, 0, 1, 0, 0);
    add(0, 0, 0,     0,     0, 1, 32'hBAD,      0, 0,      0, 0, 0, 0, 0);
    add(0, 0, 0,     0,     0, 0, 0,            0, 0,      0, 0, 0, 0, 1);
    add(0, 0, 0,     0,     0, 0, 0,            0, 0,      0, 0, 0, 0, 1);

    do_reset();
    for (int i = 0; i < tv.size(); i++) apply_row(i, tv[i]);

    // Reset drops outstanding owners; a late response is then a stray
    do_reset();
    @(negedge clk_i);
    m1_req_i = 1; m1_addr_i = 32'h500; s_gnt_i = 1;
    #1 chk("stale_grant", m1_gnt_o, 1);
    @(negedge clk_i);
    idle_inputs(); rst_i = 1;
    @(negedge clk_i);
    rst_i = 0; s_rvalid_i = 1; s_rdata_i = 32'h55;
    #1;
    chk("stale_rv1", m1_rvalid_o, 0);
    chk("stale_rv0", m0_rvalid_o, 0);
    @(negedge clk_i);
    idle_inputs();
    #1 chk("stale_err", err_o, 1);
    @(negedge clk_i);
    #1 chk("stale_err_sticky", err_o, 1);

    // Locked master abandoning its request
    do_reset();
    @(negedge clk_i);
    m0_req_i = 1; m0_addr_i = 32'h40; s_gnt_i = 0;
    #1 chk("lock_req", s_req_o, 1);
    @(negedge clk_i);
    m0_req_i = 0; m1_req_i = 1; m1_addr_i = 32'h44;
    #1 chk("lock_drop_err_pre", err_o, 0);
    @(negedge clk_i);
    #1;
    chk("lock_drop_err", err_o, 1);
    chk("lock_drop_addr", s_addr_o, 32'h44);

    // Both masters held continuously
    do_reset();
    prev = -1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      m0_req_i = 1; m1_req_i = 1; m0_addr_i = 32'h10; m1_addr_i = 32'h20;
      s_gnt_i = 1; s_rvalid_i = (k > 0); s_rdata_i = k;
`ifdef OBI_ARB_ROUND_ROBIN_EN
      exp1 = (k % 2 == 0);
`else
      exp1 = 1;
`endif
      #1;
      chk($sformatf("both_gnt1_%0d", k), m1_gnt_o, exp1);
      chk($sformatf("both_gnt0_%0d", k), m0_gnt_o, !exp1);
      if (k > 0) begin
        chk($sformatf("both_rv1_%0d", k), m1_rvalid_o, prev == 1);
        chk($sformatf("both_rv0_%0d", k), m0_rvalid_o, prev == 0);
      end
      prev = exp1 ? 1 : 0;
    end

    // Randomized legal OBI traffic against the reference model
    do_reset();
    g0_prev = 0; g1_prev = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_i);
      if (!m0_req_i || g0_prev) begin
        m0_req_i = $urandom_range(0, 1); m0_addr_i = $urandom;
      end
      if (!m1_req_i || g1_prev) begin
        m1_req_i = $urandom_range(0, 1); m1_addr_i = $urandom;
        m1_we_i = $urandom_range(0, 1); m1_be_i = $urandom; m1_wdata_i = $urandom;
      end
      s_gnt_i    = ($urandom_range(0, 3) != 0);
      s_rvalid_i = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
      s_rdata_i  = $urandom;
      #1;
      full  = (mq.size() == MAXO);
      e_req = (m0_req_i || m1_req_i) && !full;
      if (lock_v)                      sel = lock_w;
      else if (m0_req_i && !m1_req_i)  sel = 0;
      else if (m1_req_i && !m0_req_i)  sel = 1;
      else                             sel = conflict_winner();
      e_gnt = e_req && s_gnt_i;
      chk("rnd_s_req", s_req_o, e_req);
      if (e_req) begin
        chk("rnd_s_addr", s_addr_o, (sel == 0) ? m0_addr_i : m1_addr_i);
        chk("rnd_s_we", s_we_o, (sel == 1) && m1_we_i);
        chk("rnd_s_be", s_be_o, (sel == 0) ? 4'hF : m1_be_i);
        chk("rnd_s_wdata", s_wdata_o, (sel == 0) ? 32'h0 : m1_wdata_i);
      end
      chk("rnd_gnt0", m0_gnt_o, e_gnt && sel == 0);
      chk("rnd_gnt1", m1_gnt_o, e_gnt && sel == 1);
      chk("rnd_rv0", m0_rvalid_o, s_rvalid_i && mq.size() > 0 && mq[0] == 0);
      chk("rnd_rv1", m1_rvalid_o, s_rvalid_i && mq.size() > 0 && mq[0] == 1);
      chk("rnd_rdata0", m0_rdata_o, s_rdata_i);
      chk("rnd_rdata1", m1_rdata_o, s_rdata_i);
      chk("rnd_err", err_o, m_err);
      if (s_rvalid_i) begin
        if (mq.size() == 0) m_err = 1;
        else void'(mq.pop_front());
      end
      if (e_gnt) begin
        mq.push_back(sel);
`ifdef OBI_ARB_ROUND_ROBIN_EN
        rr_last = sel;
`endif
      end
      if (lock_v) begin
        if (!((sel == 0) ? m0_req_i : m1_req_i)) begin
          m_err = 1; lock_v = 0;
        end else if (s_gnt_i) begin
          lock_v = 0;
        end
      end else if (e_req && !s_gnt_i) begin
        lock_v = 1; lock_w = sel;
      end
      g0_prev = e_gnt && sel == 0;
      g1_prev = e_gnt && sel == 1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
